// File: rtl/div_unit_pkg.sv
// div_unit_pkg: funct3 codes, FSM state encodings and op-decode helpers for div_unit
package div_unit_pkg;
  typedef logic [2:0] funct3_t;
  localparam funct3_t F3_DIV  = 3'b100;
  localparam funct3_t F3_DIVU = 3'b101;
  localparam funct3_t F3_REM  = 3'b110;
  localparam funct3_t F3_REMU = 3'b111;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  function automatic logic f3_signed(input funct3_t f3);
    return f3 == F3_DIV || f3 == F3_REM;
  endfunction
  function automatic logic f3_rem(input funct3_t f3);
    return f3 == F3_REM || f3 == F3_REMU;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in dividend MSB, trial subtract)
module div_step #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] rem_i,
  input  logic            msb_i,
  input  logic [SIZE-1:0] div_i,
  output logic [SIZE-1:0] rem_o,
  output logic            q_o
);
  logic [SIZE:0] sh, diff;
  assign sh    = {rem_i, msb_i};
  assign diff  = sh - {1'b0, div_i};
  assign q_o   = ~diff[SIZE];
  assign rem_o = q_o ? diff[SIZE-1:0] : sh[SIZE-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU; DIV_BYPASS_EN enables
// early completion of divide-by-zero and signed overflow
module div_unit
  import div_unit_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      f3_i,
  input  logic [SIZE-1:0] op1_i,
  input  logic [SIZE-1:0] op2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [SIZE-1:0] result_o
);
  localparam int CW = $clog2(SIZE);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] dvd_q, dvd_d, rem_q, rem_d, dvs_q, dvs_d, op1_q, op1_d, res_q, res_d;
  logic [2:0] f3_q, f3_d;
  logic s1_q, s1_d, s2_q, s2_d, z_q, z_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [SIZE-1:0] step_rem, quo, rmd, fixed;
  logic step_q, sgn, acc, z_in, ovf_in, spec_in;

  div_step #(.SIZE(SIZE)) u_step (
    .rem_i(rem_q),
    .msb_i(dvd_q[SIZE-1]),
    .div_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  assign sgn    = f3_signed(f3_i);
  assign acc    = state_q == S_IDLE && start_i;
  assign z_in   = op2_i == '0;
  assign ovf_in = sgn && op1_i == {1'b1, {(SIZE-1){1'b0}}} && op2_i == '1;
`ifdef DIV_BYPASS_EN
  assign spec_in = z_in || ovf_in;
`else
  assign spec_in = 1'b0;
`endif

  // sign flags are only latched for signed ops, so they directly gate negation
  assign quo   = (s1_q ^ s2_q) ? -dvd_q : dvd_q;
  assign rmd   = s1_q ? -rem_q : rem_q;
  assign fixed = z_q ? (f3_rem(f3_q) ? op1_q : '1) :
                 ovf_q ? (f3_rem(f3_q) ? '0 : op1_q) :
                 f3_rem(f3_q) ? rmd : quo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    op1_d   = op1_q;
    res_d   = res_q;
    f3_d    = f3_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (acc) begin
      state_d = spec_in ? S_FIX : S_CALC;
      cnt_d   = CW'(SIZE-1);
      f3_d    = f3_i;
      op1_d   = op1_i;
      s1_d    = sgn && op1_i[SIZE-1];
      s2_d    = sgn && op2_i[SIZE-1];
      dvd_d   = (sgn && op1_i[SIZE-1]) ? -op1_i : op1_i;
      dvs_d   = (sgn && op2_i[SIZE-1]) ? -op2_i : op2_i;
      rem_d   = '0;
      z_d     = z_in;
      ovf_d   = ovf_in;
      busy_d  = 1'b1;
    end else if (state_q == S_CALC) begin
      rem_d   = step_rem;
      dvd_d   = {dvd_q[SIZE-2:0], step_q};
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? S_FIX : S_CALC;
    end else if (state_q == S_FIX) begin
      res_d   = fixed;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      op1_q   <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      op1_q   <= op1_d;
      res_q   <= res_d;
      f3_q    <= f3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit at SIZE=4 against an integer-arithmetic model
module tb_div_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [2:0] f3_i = 3'b000;
  logic [3:0] op1_i = 4'h0, op2_i = 4'h0;
  logic       busy_o, done_o;
  logic [3:0] result_o;
  int pass_cnt = 0, chk_cnt = 0, cyc = 0, t0 = 0;

  div_unit #(.SIZE(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .f3_i(f3_i),
    .op1_i(op1_i), .op2_i(op2_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_sg(input logic [2:0] f3);
    return f3 == 3'b100 || f3 == 3'b110;
  endfunction

  function automatic logic [3:0] model(input logic [2:0] f3, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, q, r;
    if (is_sg(f3)) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (b == 4'h0) begin
      q = -1;
      r = sa;
    end else if (is_sg(f3) && a == 4'h8 && b == 4'hF) begin
      q = sa;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return f3[1] ? r[3:0] : q[3:0];
  endfunction

  function automatic int lat_model(input logic [2:0] f3, input logic [3:0] a, input logic [3:0] b);
`ifdef DIV_BYPASS_EN
    if (b == 4'h0 || (is_sg(f3) && a == 4'h8 && b == 4'hF)) return 1;
`endif
    return 5;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [3:0] a, input logic [3:0] b);
    start_i = 1'b1;
    f3_i = f3;
    op1_i = a;
    op2_i = b;
    @(posedge clk);
    #1;
    t0 = cyc;
    start_i = 1'b0;
    f3_i = 3'($urandom);
    op1_i = 4'($urandom);
    op2_i = 4'($urandom);
    chk("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp, input int exp_lat);
    while (!done_o && cyc - t0 < 20) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    chk({tag, "_res"}, 32'(result_o), 32'(exp));
    chk({tag, "_busy_low"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [3:0] a, input logic [3:0] b);
    issue(f3, a, b);
    wait_done(tag, model(f3, a, b), lat_model(f3, a, b));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    logic [2:0] codes [4];
    logic [2:0] f;
    logic [3:0] a, b;
    int dones;
    codes[0] = 3'b100; codes[1] = 3'b101; codes[2] = 3'b110; codes[3] = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);

    run_op("div_m7_2", 3'b100, 4'b1001, 4'b0010);
    run_op("rem_m7_2", 3'b110, 4'b1001, 4'b0010);
    run_op("divu_13_3", 3'b101, 4'b1101, 4'b0011);
    run_op("remu_13_3", 3'b111, 4'b1101, 4'b0011);
    run_op("div_ovf", 3'b100, 4'b1000, 4'b1111);
    run_op("rem_ovf", 3'b110, 4'b1000, 4'b1111);
    run_op("divu_z", 3'b101, 4'b1101, 4'b0000);
    run_op("remu_z", 3'b111, 4'b1101, 4'b0000);
    run_op("div_z", 3'b100, 4'b0100, 4'b0000);
    run_op("rem_z_neg", 3'b110, 4'b1010, 4'b0000);

    issue(3'b111, 4'b0111, 4'b0010);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    f3_i = 3'b101;
    op1_i = 4'hF;
    op2_i = 4'h1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done("remu_7_2_ovlp", 4'b0001, 5);
    issue(3'b101, 4'hF, 4'h1);
    wait_done("b2b_divu_15_1", 4'hF, 5);

    issue(3'b100, 4'b0110, 4'b0011);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_op("post_rst_div", 3'b100, 4'b0110, 4'b0011);

    for (int i = 0; i < 60; i++) begin
      f = codes[$urandom_range(0, 3)];
      a = 4'($urandom);
      b = 4'($urandom);
      if ($urandom_range(0, 7) == 0) b = 4'h0;
      if ($urandom_range(0, 9) == 0) begin
        a = 4'h8;
        b = 4'hF;
      end
      run_op($sformatf("rnd%0d_f%0b_%0h_%0h", i, f, a, b), f, a, b);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions: the inverse of the multiply path next to `alu` in the execute stage. It accepts one operation through a start/done handshake, produces one quotient bit per cycle, and then applies RISC-V sign and special-case rules. Execute stalls on `busy_o` and takes `result_o` when `done_o` pulses.

## Interface
- `SIZE`, default 32: operand/result width in bits, ≥ 2. Benches use 4.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: request; sampled only while idle.
- `f3_i`  in  `Funct3Bus`: `F3_DIV`=100, `F3_DIVU`=101, `F3_REM`=110, `F3_REMU`=111.
- `op1_i`  in  SIZE: dividend.
- `op2_i`  in  SIZE: divisor.
- `busy_o`  out  1: operation in progress; reset 0.
- `done_o`  out  1: one-cycle result-valid pulse; reset 0.
- `result_o`  out  SIZE: quotient or remainder, held until the next completion; reset 0.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE: when `start_i`=1, latch `f3_i` and the operands.
  - Signed ops (f3[0]=0) latch magnitudes plus the operand sign bits.
  - Clear the partial remainder and load the bit counter with SIZE-1.
  - Set `busy_o`=1 and go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - When the counter reaches 0, go to FIX.
- FIX: select the result, register it into `result_o`, pulse `done_o`=1, clear `busy_o`, return to IDLE.
  - Result select: f3[1]=0 gives the quotient, f3[1]=1 gives the remainder.
  - Signed quotient is negated if sign(op1) xor sign(op2).
  - Signed remainder takes the sign of op1.
- Special cases, applied in FIX and overriding the computed value:
  - Divisor 0: quotient = all ones, remainder = op1, for both signed and unsigned ops.
  - Signed overflow (op1 = most-negative value, op2 = all ones): quotient = op1, remainder = 0.
- All arithmetic is SIZE bits with an internal SIZE+1-bit trial subtraction. There are no traps or flags.
- `start_i` while busy is ignored. Input changes after acceptance have no effect.
- `start_i` in the same cycle as `done_o`=1 is accepted, because the FSM is already IDLE. This gives back-to-back operation with no gap cycle.
- `rst` at any edge, including mid-CALC: state returns to IDLE, all outputs go to 0, and the in-flight operation is discarded with no `done_o`.

## Timing
- Acceptance happens at clock edge t0 (`start_i`=1 in IDLE).
  - After t0: `busy_o`=1.
  - Edges t0+1 … t0+SIZE: CALC steps.
  - Edge t0+SIZE+1: FIX registers the result.
- `done_o` and the new `result_o` are visible for the cycle after edge t0+SIZE+1. Latency is SIZE+1 cycles, which is 5 at SIZE=4.
- `busy_o` is low in the same cycle `done_o` is high.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DIV_BYPASS_EN` defined:
  - Divide-by-zero and signed overflow are detected in IDLE at acceptance.
  - The FSM skips CALC and goes straight to FIX, so `done_o` appears after edge t0+1 (latency 1).
  - Results are identical to the non-bypass case.
- `DIV_BYPASS_EN` not defined: every operation, special cases included, takes the uniform SIZE+1 latency.

## Structure
- `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU` and the state encodings go in `cpu/define.v`, alongside the existing `Funct3Bus` and `F3_*` definitions.
- One sub-module, `div_step`: a combinational restoring step, parameterised by SIZE. It takes the remainder, the dividend MSB and the divisor, and returns the next remainder and the quotient bit.
- The FSM, counter and sign fix-up stay in `div_unit`.

## Test plan
All scenarios use SIZE=4.
- DIV op1=1001 (-7), op2=0010 (2) → `result_o`=1101 (-3), `done_o` exactly 5 cycles after acceptance. REM with the same operands → 1111 (-1).
- DIVU op1=1101 (13), op2=0011 → 0100. REMU with the same operands → 0001.
- DIV op1=1000 (-8), op2=1111 (-1) → 1000. REM with the same operands → 0000. Check latency is 5 without `DIV_BYPASS_EN` and 1 with it.
- DIVU 1101 by 0000 → 1111. REMU 1101 by 0000 → 1101. DIV 0100 by 0000 → 1111.
- Back-to-back and overlap: start REMU 0111 (7) / 0010. Then:
  - Re-assert `start_i` with different operands mid-CALC → ignored.
  - Start a new op in the `done_o` cycle → accepted, and its result arrives 5 cycles later.
- Reset: assert `rst` 2 cycles into CALC → next cycle `busy_o`=0, `done_o`=0, `result_o`=0000. No `done_o` follows, and the next start works normally.
